// File: rtl/eyeriss_pkg.sv
// rtl/eyeriss_pkg.sv - shared types for the row-stationary PE; sat_add exists only with PE_SATURATE_EN.
package eyeriss_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, FILL, MAC, PSUM, OUT} pe_rs_state_e;

`ifdef PE_SATURATE_EN
  // Operands arrive sign-extended to 64 bits; w is the target width (w <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction
`endif

endpackage

// File: rtl/pe_spad.sv
// rtl/pe_spad.sv - FILT_MAX x DATA_W scratchpad with indexed write or shift-in at entry 0.
module pe_spad #(
  parameter int DATA_W   = 16,
  parameter int FILT_MAX = 8,
  parameter int IDX_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic                       shift_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [FILT_MAX*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [FILT_MAX];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FILT_MAX; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < FILT_MAX; i++) mem[i] <= '0;
    end else if (shift_en) begin
      mem[0] <= wr_data;
      for (int i = 1; i < FILT_MAX; i++) mem[i] <= mem[i-1];
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < FILT_MAX; g++) begin : g_rd
    assign rd_data[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/pe_rs_conv1d.sv
// rtl/pe_rs_conv1d.sv - row-stationary Eyeriss PE: one filter row slid over an image-row stream.
// Define PE_SATURATE_EN for saturating accumulation; default build wraps.
module pe_rs_conv1d
  import eyeriss_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PSUM_W   = 32,
  parameter int FILT_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [$clog2(FILT_MAX):0]  cfg_len,
  input  logic [CNT_W-1:0]           cfg_num_out,
  input  logic [DATA_W-1:0]          weight_val,
  input  logic                       weight_valid,
  output logic                       weight_ready,
  input  logic [DATA_W-1:0]          image_val,
  input  logic                       image_valid,
  output logic                       image_ready,
  input  logic [PSUM_W-1:0]          psum_in,
  input  logic                       psum_in_valid,
  output logic                       psum_in_ready,
  output logic [PSUM_W-1:0]          psum_out,
  output logic                       psum_out_valid,
  input  logic                       psum_out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = $clog2(FILT_MAX) + 1;
  localparam int IDX_W = (FILT_MAX > 1) ? $clog2(FILT_MAX) : 1;

  pe_rs_state_e state, state_nxt;
  logic [LEN_W-1:0] len_q, wcnt, pix_cnt, mac_i, len_eff, pix_need, win_sel;
  logic [CNT_W-1:0] num_q, out_cnt, num_eff;
  logic signed [PSUM_W-1:0] acc, acc_sum, out_sum, prod_ext;
  logic signed [DATA_W-1:0] w_cur, x_cur;
  logic signed [2*DATA_W-1:0] prod;
  logic [FILT_MAX*DATA_W-1:0] w_flat, x_flat;
  logic w_fire, img_fire, ps_fire, out_fire, fill_last, out_last, start;

  assign weight_ready  = (state == LOAD_W);
  assign image_ready   = (state == FILL);
  assign psum_in_ready = (state == PSUM);
  assign busy          = (state != IDLE);

  assign start    = (state == IDLE) && cfg_start;
  assign w_fire   = weight_valid && weight_ready;
  assign img_fire = image_valid && image_ready;
  assign ps_fire  = psum_in_valid && psum_in_ready;
  assign out_fire = psum_out_valid && psum_out_ready;

  assign len_eff = (cfg_len == '0 || cfg_len > LEN_W'(FILT_MAX)) ? LEN_W'(FILT_MAX) : cfg_len;
  assign num_eff = (cfg_num_out == '0) ? CNT_W'(1) : cfg_num_out;

  // The first output of a pass primes the whole window; later ones slide by one pixel.
  assign pix_need  = (out_cnt == '0) ? len_q : LEN_W'(1);
  assign fill_last = img_fire && (pix_cnt + LEN_W'(1) == pix_need);
  assign out_last  = out_fire && (out_cnt + CNT_W'(1) == num_q);

  pe_spad #(.DATA_W(DATA_W), .FILT_MAX(FILT_MAX), .IDX_W(IDX_W)) u_wspad (
    .clk(clk), .rst(rst), .clr(1'b0), .wr_en(w_fire), .shift_en(1'b0),
    .wr_idx(wcnt[IDX_W-1:0]), .wr_data(weight_val), .rd_data(w_flat)
  );

  pe_spad #(.DATA_W(DATA_W), .FILT_MAX(FILT_MAX), .IDX_W(IDX_W)) u_win (
    .clk(clk), .rst(rst), .clr(start), .wr_en(1'b0), .shift_en(img_fire),
    .wr_idx('0), .wr_data(image_val), .rd_data(x_flat)
  );

  // w[i] pairs with win[len-1-i], so w[0] meets the oldest pixel.
  assign win_sel  = len_q - LEN_W'(1) - mac_i;
  assign w_cur    = w_flat[mac_i[IDX_W-1:0]*DATA_W +: DATA_W];
  assign x_cur    = x_flat[win_sel[IDX_W-1:0]*DATA_W +: DATA_W];
  assign prod     = w_cur * x_cur;
  assign prod_ext = PSUM_W'(prod);

`ifdef PE_SATURATE_EN
  assign acc_sum = PSUM_W'(sat_add(64'(acc), 64'(prod_ext), PSUM_W));
  assign out_sum = PSUM_W'(sat_add(64'(acc), 64'($signed(psum_in)), PSUM_W));
`else
  assign acc_sum = acc + prod_ext;
  assign out_sum = acc + $signed(psum_in);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cfg_start) state_nxt = LOAD_W;
      LOAD_W:  if (w_fire && wcnt == len_q - LEN_W'(1)) state_nxt = FILL;
      FILL:    if (fill_last) state_nxt = MAC;
      MAC:     if (mac_i == len_q - LEN_W'(1)) state_nxt = PSUM;
      PSUM:    if (ps_fire) state_nxt = OUT;
      OUT:     if (out_fire) state_nxt = out_last ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0; num_q <= '0; wcnt <= '0; pix_cnt <= '0; mac_i <= '0; out_cnt <= '0;
      acc <= '0; psum_out <= '0; psum_out_valid <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (cfg_start) begin
          len_q <= len_eff; num_q <= num_eff;
          wcnt <= '0; pix_cnt <= '0; out_cnt <= '0;
        end
        LOAD_W: if (w_fire) wcnt <= wcnt + LEN_W'(1);
        FILL: if (img_fire) begin
          if (fill_last) begin
            pix_cnt <= '0; mac_i <= '0; acc <= '0;
          end else begin
            pix_cnt <= pix_cnt + LEN_W'(1);
          end
        end
        MAC: begin
          acc   <= acc_sum;
          mac_i <= mac_i + LEN_W'(1);
        end
        PSUM: if (ps_fire) begin
          psum_out <= out_sum; psum_out_valid <= 1'b1;
        end
        OUT: if (out_fire) begin
          psum_out_valid <= 1'b0; out_cnt <= out_cnt + CNT_W'(1); done <= out_last;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_rs_conv1d.sv
// tb/tb_pe_rs_conv1d.sv - scoreboard bench for pe_rs_conv1d (honours PE_SATURATE_EN).
module tb_pe_rs_conv1d;

  localparam int DATA_W = 16, PSUM_W = 32, FILT_MAX = 8, CNT_W = 8;

  logic clk = 1'b0, rst;
  logic cfg_start;
  logic [$clog2(FILT_MAX):0] cfg_len;
  logic [CNT_W-1:0] cfg_num_out;
  logic [DATA_W-1:0] weight_val, image_val;
  logic weight_valid, weight_ready, image_valid, image_ready;
  logic [PSUM_W-1:0] psum_in, psum_out;
  logic psum_in_valid, psum_in_ready, psum_out_valid, psum_out_ready, busy, done;

  pe_rs_conv1d #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .FILT_MAX(FILT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_num_out(cfg_num_out),
    .weight_val(weight_val), .weight_valid(weight_valid), .weight_ready(weight_ready),
    .image_val(image_val), .image_valid(image_valid), .image_ready(image_ready),
    .psum_in(psum_in), .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
    .psum_out(psum_out), .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fails = 0;
  longint exp_q[$];
  longint w_arr[FILT_MAX], img_arr[16], ps_arr[8];
  int stall = 0, done_cnt = 0;
  bit stall_seen = 0;
  longint stall_val = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fold(input longint v);
`ifdef PE_SATURATE_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (psum_out_valid) begin
        check_eq("no_img_in_out", longint'(image_ready), 0);
        if (!psum_out_ready) begin
          if (stall_seen) check_eq("hold_stable", $signed(psum_out), stall_val);
          stall_seen = 1;
          stall_val  = $signed(psum_out);
        end else begin
          stall_seen = 0;
          if (exp_q.size() == 0) check_eq("unexpected_out", $signed(psum_out), 0);
          else check_eq("psum_out", $signed(psum_out), exp_q.pop_front());
        end
      end else begin
        stall_seen = 0;
      end
    end
  end

  initial begin
    psum_out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (psum_out_valid && stall > 0) begin
        psum_out_ready = 1'b0;
        stall--;
      end else begin
        psum_out_ready = 1'b1;
      end
    end
  end

  // ch: 0 weight, 1 image, 2 psum_in. Returns the number of cycles spent presenting the beat.
  task automatic send(input int ch, input longint val, output int waits);
    logic r;
    waits = 0;
    case (ch)
      0: begin weight_val = DATA_W'(val); weight_valid = 1'b1; end
      1: begin image_val = DATA_W'(val); image_valid = 1'b1; end
      default: begin psum_in = PSUM_W'(val); psum_in_valid = 1'b1; end
    endcase
    do begin
      @(negedge clk);
      r = (ch == 0) ? weight_ready : (ch == 1) ? image_ready : psum_in_ready;
      @(posedge clk); #1;
      waits++;
    end while (!r && waits < 300);
    if (!r) check_eq($sformatf("timeout_ch%0d", ch), 0, 1);
    weight_valid = 1'b0; image_valid = 1'b0; psum_in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int l, input int n);
    cfg_len = l[$clog2(FILT_MAX):0]; cfg_num_out = n[CNT_W-1:0]; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic run_pass(input int cfg_l, input int cfg_n, input bit mid_start);
    int len, num, d0, t, waits, npix;
    longint acc;
    len = (cfg_l == 0 || cfg_l > FILT_MAX) ? FILT_MAX : cfg_l;
    num = (cfg_n == 0) ? 1 : cfg_n;
    d0 = done_cnt;
    for (int k = 0; k < num; k++) begin
      acc = 0;
      for (int i = 0; i < len; i++) acc = fold(acc + w_arr[i] * img_arr[k+i]);
      exp_q.push_back(fold(acc + ps_arr[k]));
    end
    pulse_start(cfg_l, cfg_n);
    for (int i = 0; i < len; i++) send(0, w_arr[i], waits);
    for (int k = 0; k < num; k++) begin
      npix = (k == 0) ? len : 1;
      for (int p = 0; p < npix; p++) begin
        send(1, img_arr[(k == 0) ? p : len - 1 + k], waits);
        if (mid_start && k == 0 && p == 0) begin
          pulse_start(1, 9);
          cfg_len = cfg_l[$clog2(FILT_MAX):0];
        end
      end
      send(2, ps_arr[k], waits);
      check_eq("mac_cycles", waits, len + 1);
    end
    t = 0;
    while (busy && t < 300) begin @(posedge clk); #1; t++; end
    check_eq("pass_end_busy", longint'(busy), 0);
    repeat (2) begin @(posedge clk); #1; end
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int waits, d0;
    rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_num_out = '0;
    weight_val = '0; weight_valid = 1'b0; image_val = '0; image_valid = 1'b0;
    psum_in = '0; psum_in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_eq("rst_psum_out", psum_out, 0);
    check_eq("rst_out_valid", longint'(psum_out_valid), 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_done", longint'(done), 0);
    check_eq("rst_wready", longint'(weight_ready), 0);
    check_eq("rst_iready", longint'(image_ready), 0);
    check_eq("rst_pready", longint'(psum_in_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic sliding window
    w_arr = '{default: 0}; img_arr = '{default: 0}; ps_arr = '{default: 0};
    w_arr[0] = 1; w_arr[1] = 2; w_arr[2] = 3;
    img_arr[0] = 1; img_arr[1] = 2; img_arr[2] = 3; img_arr[3] = 4;
    ps_arr[0] = 10; ps_arr[1] = 10;
    run_pass(3, 2, 0);

    // 2: backpressure on the first output
    stall = 5;
    run_pass(3, 2, 0);
    check_eq("stall_consumed", stall, 0);

    // 3: single-tap filter with negative values
    w_arr = '{default: 0}; img_arr = '{default: 0}; ps_arr = '{default: 0};
    w_arr[0] = -2; img_arr[0] = 5; img_arr[1] = -7;
    run_pass(1, 2, 0);

    // 4: overflow on the final psum add
    w_arr[0] = 32767; img_arr[0] = 32767; ps_arr[0] = 2147483647;
    run_pass(1, 1, 0);

    // 5: abort mid-MAC by reset, then a clean pass
    w_arr = '{default: 0}; img_arr = '{default: 0}; ps_arr = '{default: 0};
    w_arr[0] = 1; w_arr[1] = 2; w_arr[2] = 3;
    img_arr[0] = 1; img_arr[1] = 2; img_arr[2] = 3; img_arr[3] = 4;
    ps_arr[0] = 10; ps_arr[1] = 10;
    d0 = done_cnt;
    pulse_start(3, 2);
    for (int i = 0; i < 3; i++) send(0, w_arr[i], waits);
    for (int i = 0; i < 3; i++) send(1, img_arr[i], waits);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_psum_out", psum_out, 0);
    check_eq("abort_busy", longint'(busy), 0);
    check_eq("abort_out_valid", longint'(psum_out_valid), 0);
    check_eq("abort_pready", longint'(psum_in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_no_done", done_cnt - d0, 0);
    run_pass(3, 2, 0);

    // 6: cfg_start during FILL is ignored
    run_pass(3, 2, 1);

    // 7: illegal cfg_len / cfg_num_out clamp to FILT_MAX / 1
    for (int i = 0; i < FILT_MAX; i++) begin
      w_arr[i] = i - 3;
      img_arr[i] = 2 * i + 1;
    end
    ps_arr[0] = -5;
    run_pass(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
